fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction memory.
- Holds the program counter and drives the word address into instruction memory.
- Registers the returned instruction into an IF/ID output register with a valid flag.
- Handles stall, branch/jump redirect with flush, and sticky fault detection for misaligned or out-of-range PCs.

---
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses instruction memory, registers IF/ID with sticky PC fault.
// Latency 1 cycle (word at pc lands in if_instr on the next edge); stall holds everything, redirect flushes.
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    MEM_SIZE   = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [DATA_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_pc_plus4,
  output logic                  if_valid,
  output logic                  fault,
  output logic [DATA_WIDTH-1:0] fault_pc,
  output logic [31:0]           fetch_count
);

  localparam logic [DATA_WIDTH-1:0] PC_LIMIT = DATA_WIDTH'(MEM_SIZE * 4);
  localparam logic [DATA_WIDTH-1:0] FOUR     = DATA_WIDTH'(4);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t                  state, state_nx;
  logic [DATA_WIDTH-1:0]   pc_nx, if_instr_nx, if_pc_nx, if_pc_plus4_nx, fault_pc_nx;
  logic                    if_valid_nx, fault_nx;
  logic [31:0]             fetch_count_nx;
  logic                    pc_bad, rpc_bad;

  // Full-width compare so stray upper PC bits are caught rather than aliased.
  assign pc_bad     = (pc[1:0] != 2'b00) || (pc >= PC_LIMIT);
  assign rpc_bad    = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= PC_LIMIT);
  assign instr_addr = pc[ADDR_WIDTH+1:2];

  always_comb begin
    state_nx       = state;
    pc_nx          = pc;
    if_instr_nx    = if_instr;
    if_pc_nx       = if_pc;
    if_pc_plus4_nx = if_pc_plus4;
    if_valid_nx    = if_valid;
    fault_nx       = fault;
    fault_pc_nx    = fault_pc;
    fetch_count_nx = fetch_count;
    case (state)
      BOOT: begin
        state_nx    = RUN;
        if_valid_nx = 1'b0;
      end
      RUN: begin
        if (pc_bad) begin
          state_nx    = FAULT;
          fault_nx    = 1'b1;
          fault_pc_nx = pc;
          if_valid_nx = 1'b0;
        end else if (redirect && rpc_bad) begin
          state_nx    = FAULT;
          fault_nx    = 1'b1;
          fault_pc_nx = redirect_pc;
          if_valid_nx = 1'b0;
        end else if (redirect) begin
          pc_nx       = redirect_pc;
          if_valid_nx = 1'b0;
        end else if (!stall) begin
          if_instr_nx    = instr;
          if_pc_nx       = pc;
          if_pc_plus4_nx = pc + FOUR;
          if_valid_nx    = 1'b1;
          pc_nx          = pc + FOUR;
          fetch_count_nx = fetch_count + 32'd1;
        end
      end
      FAULT: begin
        if_valid_nx = 1'b0;
        fault_nx    = 1'b1;
      end
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus4 <= FOUR;
      if_valid    <= 1'b0;
      fault       <= 1'b0;
      fault_pc    <= '0;
      fetch_count <= '0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      if_instr    <= if_instr_nx;
      if_pc       <= if_pc_nx;
      if_pc_plus4 <= if_pc_plus4_nx;
      if_valid    <= if_valid_nx;
      fault       <= fault_nx;
      fault_pc    <= fault_pc_nx;
      fetch_count <= fetch_count_nx;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stall/redirect traffic against a reference model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [5:0]  instr_addr;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  logic [31:0] mem [64];
  assign instr = mem[instr_addr];

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_addr  (instr_addr),
    .instr       (instr),
    .pc          (pc),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4),
    .if_valid    (if_valid),
    .fault       (fault),
    .fault_pc    (fault_pc),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state, described by what the stage has architecturally done.
  bit          m_booting;
  bit          m_faulted;
  logic [31:0] m_pc, m_ifi, m_ifpc, m_fpc, m_cnt;
  bit          m_vld;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd256);
  endfunction

  task automatic model_reset();
    m_booting = 1; m_faulted = 0; m_pc = 0; m_ifi = 0; m_ifpc = 0;
    m_vld = 0; m_fpc = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit s, input bit r, input logic [31:0] rp);
    if (m_booting) m_booting = 0;
    else if (!m_faulted) begin
      if (is_bad(m_pc))          begin m_faulted = 1; m_fpc = m_pc; m_vld = 0; end
      else if (r && is_bad(rp))  begin m_faulted = 1; m_fpc = rp;   m_vld = 0; end
      else if (r)                begin m_pc = rp; m_vld = 0; end
      else if (!s) begin
        m_ifi = mem[m_pc / 4]; m_ifpc = m_pc; m_vld = 1;
        m_pc = m_pc + 4; m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},          pc,                 m_pc);
    chk({tag, ".instr_addr"},  {26'd0, instr_addr}, (m_pc / 4) % 64);
    chk({tag, ".if_valid"},    {31'd0, if_valid},  {31'd0, m_vld});
    chk({tag, ".if_instr"},    if_instr,           m_ifi);
    chk({tag, ".if_pc"},       if_pc,              m_ifpc);
    chk({tag, ".if_pc_plus4"}, if_pc_plus4,        m_ifpc + 4);
    chk({tag, ".fault"},       {31'd0, fault},     {31'd0, m_faulted});
    chk({tag, ".fault_pc"},    fault_pc,           m_fpc);
    chk({tag, ".fetch_count"}, fetch_count,        m_cnt);
  endtask

  task automatic step(input string tag, input bit s, input bit r, input logic [31:0] rp);
    stall = s; redirect = r; redirect_pc = rp;
    @(posedge clk);
    model_edge(s, r, rp);
    #1 check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1 check_all("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] rp;
  int          since_fault;

  initial begin
    rst_n = 1'b0; stall = 0; redirect = 0; redirect_pc = 0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0001; mem[1] = 32'h2009_0002; mem[2] = 32'h0109_5020;
    model_reset();
    #12 check_all("rst");
    @(negedge clk) rst_n = 1'b1;

    // Boot cycle, then three sequential fetches.
    step("boot", 0, 0, 0);
    step("f0", 0, 0, 0);
    chk("t1.instr0", if_instr, 32'h2008_0001);
    step("f1", 0, 0, 0);
    chk("t1.instr1", if_instr, 32'h2009_0002);
    step("f2", 0, 0, 0);
    chk("t1.instr2", if_instr, 32'h0109_5020);
    chk("t1.if_pc2", if_pc, 32'h8);
    chk("t1.count", fetch_count, 32'd3);

    // Stall at pc=8 (reached via a redirect to 8).
    step("rd8", 0, 1, 32'h8);
    step("st0", 1, 0, 0);
    step("st1", 1, 0, 0);
    chk("t2.pc_held", pc, 32'h8);
    step("res", 0, 0, 0);
    chk("t2.if_pc", if_pc, 32'h8);

    // Redirect wins over stall.
    step("rdst", 1, 1, 32'h20);
    chk("t3.pc", pc, 32'h20);
    step("rdf", 0, 0, 0);
    chk("t3.if_pc", if_pc, 32'h20);
    step("rdself", 0, 1, pc);

    // Misaligned redirect faults; later activity is ignored.
    step("mis", 0, 1, 32'h22);
    chk("t4.fault_pc", fault_pc, 32'h22);
    step("fz0", 0, 1, 32'h40);
    step("fz1", 1, 0, 0);
    step("fz2", 0, 0, 0);

    // Run off the end of memory.
    do_reset();
    step("boot2", 0, 0, 0);
    step("rdF8", 0, 1, 32'hF8);
    step("eF8", 0, 0, 0);
    step("eFC", 0, 0, 0);
    chk("t5.if_pcFC", if_pc, 32'hFC);
    step("e100", 0, 0, 0);
    chk("t5.fault_pc", fault_pc, 32'h100);
    step("e101", 0, 0, 0);

    // Asynchronous reset between edges at pc=0x14.
    do_reset();
    step("boot3", 0, 0, 0);
    for (int i = 0; i < 5; i++) step("run14", 0, 0, 0);
    chk("t6.pc", pc, 32'h14);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_all("arst");
    @(posedge clk); #1 check_all("arst_hold");
    @(negedge clk) rst_n = 1'b1;
    step("boot4", 0, 0, 0);
    step("r0", 0, 0, 0);
    chk("t6.if_pc0", if_pc, 32'h0);

    // Random traffic; re-reset a few cycles after any fault.
    since_fault = 0;
    for (int n = 0; n < 800; n++) begin
      case ($urandom_range(0, 19))
        0:       rp = $urandom_range(0, 63) * 4 + $urandom_range(1, 3);
        1:       rp = $urandom_range(64, 1 << 20) * 4;
        2, 3:    rp = 32'hF0 + $urandom_range(0, 3) * 4;
        default: rp = $urandom_range(0, 63) * 4;
      endcase
      step("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), rp);
      if (m_faulted) since_fault++;
      if (since_fault > 3) begin
        since_fault = 0;
        do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
